// File: rtl/ahb_params_pkg.sv
// Shared AHB encodings: transfer types, response codes and default-slave states.
package ahb_params_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  // A transfer carries data only for NONSEQ and SEQ.
  function automatic logic trans_valid(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: two-cycle ERROR response for unmapped transfers,
// plus a saturating count of the ERROR responses it has issued.
module ahb_default_slave
  import ahb_params_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hready,     // global HREADY: address phase accepted
  input  logic             err_req,    // valid transfer decoding to the default slave
  input  logic             err_clr,
  output logic             ds_hready,
  output hresp_t           ds_hresp,
  output logic [CNT_W-1:0] err_cnt
);

  ds_state_t        state_reg, state_next;
  logic [CNT_W-1:0] err_cnt_reg;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= DS_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; ERR1 is always followed by ERR2, ERR2 may chain into a new error.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DS_IDLE: if (hready && err_req) state_next = DS_ERR1;
      DS_ERR1: state_next = DS_ERR2;
      DS_ERR2: state_next = (hready && err_req) ? DS_ERR1 : DS_IDLE;
      default: state_next = DS_IDLE;
    endcase
  end

  // Outputs depend only on the current state, keeping HREADY free of combinational loops.
  always_comb begin
    ds_hready = 1'b1;
    ds_hresp  = OKAY;
    case (state_reg)
      DS_ERR1: begin
        ds_hready = 1'b0;
        ds_hresp  = ERROR;
      end
      DS_ERR2: ds_hresp = ERROR;
      default: ;
    endcase
  end

  // Error counter: clear wins over a simultaneous entry into ERR1; saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               err_cnt_reg <= '0;
    else if (err_clr)                                      err_cnt_reg <= '0;
    else if (state_next == DS_ERR1 && err_cnt_reg != '1)   err_cnt_reg <= err_cnt_reg + 1'b1;
  end

  assign err_cnt = err_cnt_reg;

endmodule

// File: rtl/ahb_decoder_mux.sv
// Table-driven AHB address decoder with registered data-phase owner and
// response multiplexer; unmapped transfers go to the built-in default slave.
module ahb_decoder_mux
  import ahb_params_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLV_BASE = {32'h0000_0800, 32'h0000_0400},
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLV_MASK = {32'hFFFF_FC00, 32'hFFFF_FC00},
  parameter int GATE_HSEL  = 1,
  parameter int CNT_W      = 16,
  localparam int ID_W      = $clog2(NUM_SLAVES + 1)
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  output logic [NUM_SLAVES-1:0]        HSEL_S,
  output logic                         HSEL_DEFAULT,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [2*NUM_SLAVES-1:0]      HRESP_S,
  input  logic [DATA_W*NUM_SLAVES-1:0] HRDATA_S,
  output logic                         HREADY,
  output logic [1:0]                   HRESP,
  output logic [DATA_W-1:0]            HRDATA,
  output logic [ID_W-1:0]              dslave_id,
  input  logic                         err_clr,
  output logic [CNT_W-1:0]             err_cnt
);

  localparam logic [ID_W-1:0] DEF_ID = ID_W'(NUM_SLAVES);

  logic [NUM_SLAVES-1:0] hit;
  logic [ID_W-1:0]       dec_id;
  logic                  dec_default;
  logic                  addr_valid;
  logic                  gate_ok;
  logic [ID_W-1:0]       dslave_id_reg;
  logic                  dactive_reg;
  logic                  ds_hready;
  hresp_t                ds_hresp;

  assign addr_valid = trans_valid(HTRANS);
  assign gate_ok    = addr_valid || (GATE_HSEL == 0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_map
      assign hit[gi]    = (HADDR & SLV_MASK[gi]) == SLV_BASE[gi];
      assign HSEL_S[gi] = (dec_id == ID_W'(gi)) && gate_ok;
    end
  endgenerate

  // Priority decode: scanning downward lets the lowest matching index win.
  always_comb begin
    dec_id = DEF_ID;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) dec_id = ID_W'(i);
    end
  end

  assign dec_default  = (dec_id == DEF_ID);
  assign HSEL_DEFAULT = dec_default && gate_ok;

  // Data-phase owner advances only when the address phase is accepted.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dslave_id_reg <= DEF_ID;
      dactive_reg   <= 1'b0;
    end else if (HREADY) begin
      dslave_id_reg <= dec_id;
      dactive_reg   <= addr_valid;
    end
  end

  // dactive is held for debug visibility; the mux does not need it.
  logic unused_dactive;
  assign unused_dactive = dactive_reg;

  assign dslave_id = dslave_id_reg;

  ahb_default_slave #(
    .CNT_W (CNT_W)
  ) u_default_slave (
    .clk       (HCLK),
    .rst       (HRESET),
    .hready    (HREADY),
    .err_req   (addr_valid && dec_default),
    .err_clr   (err_clr),
    .ds_hready (ds_hready),
    .ds_hresp  (ds_hresp),
    .err_cnt   (err_cnt)
  );

  // Response mux: the data-phase owner drives ready/resp/data; default slave otherwise.
  always_comb begin
    HREADY = ds_hready;
    HRESP  = ds_hresp;
    HRDATA = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dslave_id_reg == ID_W'(i)) begin
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[2*i +: 2];
        HRDATA = HRDATA_S[DATA_W*i +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed bench for ahb_decoder_mux: decode, pipelining, wait states,
// default-slave ERROR sequence, counter saturation/clear and async reset.
module tb_ahb_decoder_mux;

  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 2;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              HRESET;
  logic [AW-1:0]     HADDR;
  logic [1:0]        HTRANS;
  logic [NS-1:0]     HSEL_S;
  logic              HSEL_DEFAULT;
  logic [NS-1:0]     HREADYOUT_S;
  logic [2*NS-1:0]   HRESP_S;
  logic [DW*NS-1:0]  HRDATA_S;
  logic              HREADY;
  logic [1:0]        HRESP;
  logic [DW-1:0]     HRDATA;
  logic [IW-1:0]     dslave_id;
  logic              err_clr;
  logic [CW-1:0]     err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ahb_decoder_mux #(
    .NUM_SLAVES (NS),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .GATE_HSEL  (1),
    .CNT_W      (CW)
  ) dut (
    .HCLK         (clk),
    .HRESET       (HRESET),
    .HADDR        (HADDR),
    .HTRANS       (HTRANS),
    .HSEL_S       (HSEL_S),
    .HSEL_DEFAULT (HSEL_DEFAULT),
    .HREADYOUT_S  (HREADYOUT_S),
    .HRESP_S      (HRESP_S),
    .HRDATA_S     (HRDATA_S),
    .HREADY       (HREADY),
    .HRESP        (HRESP),
    .HRDATA       (HRDATA),
    .dslave_id    (dslave_id),
    .err_clr      (err_clr),
    .err_cnt      (err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [1:0] t, input logic [31:0] a);
    HTRANS = t;
    HADDR  = a;
    $display("[TB] t=%0t drive HTRANS=%0d HADDR=0x%08h", $time, t, a);
  endtask

  initial begin
    HRESET      = 1'b1;
    HTRANS      = 2'b00;
    HADDR       = '0;
    HREADYOUT_S = 2'b11;
    HRESP_S     = '0;
    HRDATA_S    = '0;
    err_clr     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    HRESET = 1'b0;
    @(negedge clk);
    check("rst_hready", HREADY, 1);
    check("rst_hresp", HRESP, 0);
    check("rst_hrdata", HRDATA, 0);
    check("rst_dslave", dslave_id, 2);
    check("rst_errcnt", err_cnt, 0);

    // NONSEQ to slave 0 with one wait state
    tick();
    bus(2'b10, 32'h0000_0404);
    @(negedge clk);
    check("s0_hsel", HSEL_S, 2'b01);
    check("s0_hseldef", HSEL_DEFAULT, 0);
    tick();
    bus(2'b00, 32'h0);
    HREADYOUT_S[0] = 1'b0;
    @(negedge clk);
    check("s0_owner", dslave_id, 0);
    check("s0_wait", HREADY, 0);
    check("idle_hsel_gated", HSEL_S, 2'b00);
    tick();
    HREADYOUT_S[0] = 1'b1;
    HRDATA_S[31:0] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("s0_ready", HREADY, 1);
    check("s0_rdata", HRDATA, 32'hDEAD_BEEF);
    check("s0_owner_held", dslave_id, 0);
    tick();
    @(negedge clk);
    check("idle_unmapped_owner", dslave_id, 2);
    check("idle_unmapped_ready", HREADY, 1);
    check("idle_unmapped_resp", HRESP, 0);
    check("idle_unmapped_data", HRDATA, 0);

    // Pipelined NONSEQ slave 0 then SEQ slave 1
    tick();
    HRDATA_S = {32'h2222_0001, 32'h1111_0000};
    bus(2'b10, 32'h0000_0400);
    tick();
    bus(2'b11, 32'h0000_0800);
    @(negedge clk);
    check("pipe_owner0", dslave_id, 0);
    check("pipe_data0", HRDATA, 32'h1111_0000);
    check("pipe_hsel1", HSEL_S, 2'b10);
    tick();
    bus(2'b00, 32'h0);
    @(negedge clk);
    check("pipe_owner1", dslave_id, 1);
    check("pipe_data1", HRDATA, 32'h2222_0001);

    // Single unmapped NONSEQ: two-cycle ERROR
    tick();
    bus(2'b10, 32'h0000_1000);
    @(negedge clk);
    check("err_hseldef", HSEL_DEFAULT, 1);
    check("err_hsel", HSEL_S, 2'b00);
    tick();
    bus(2'b00, 32'h0);
    @(negedge clk);
    check("err1_hready", HREADY, 0);
    check("err1_hresp", HRESP, 1);
    check("err1_cnt", err_cnt, 1);
    tick();
    @(negedge clk);
    check("err2_hready", HREADY, 1);
    check("err2_hresp", HRESP, 1);
    tick();
    @(negedge clk);
    check("err_after_idle_ready", HREADY, 1);
    check("err_after_idle_resp", HRESP, 0);
    check("err_after_idle_cnt", err_cnt, 1);

    // Back-to-back errors: saturation, then clear alongside a new error
    tick();
    bus(2'b10, 32'h0000_1000);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("b2b_err1_hready", HREADY, 0);
      tick();
      if (k == 4) err_clr = 1'b1;
      @(negedge clk);
      check("b2b_err2_hready", HREADY, 1);
      check("b2b_err2_hresp", HRESP, 1);
      check("b2b_cnt", err_cnt, (k == 0) ? 2 : 3);
      tick();
    end
    err_clr = 1'b0;
    bus(2'b00, 32'h0);
    @(negedge clk);
    check("clr_cnt", err_cnt, 0);
    check("clr_err1_hready", HREADY, 0);
    check("clr_err1_hresp", HRESP, 1);

    // Async reset during ERR1, then normal decode after release
    HRESET = 1'b1;
    #1;
    check("rstmid_hready", HREADY, 1);
    check("rstmid_hresp", HRESP, 0);
    check("rstmid_owner", dslave_id, 2);
    tick();
    HRESET = 1'b0;
    bus(2'b10, 32'h0000_0800);
    @(negedge clk);
    check("post_rst_hsel", HSEL_S, 2'b10);
    tick();
    bus(2'b00, 32'h0);
    @(negedge clk);
    check("post_rst_owner", dslave_id, 1);
    check("post_rst_data", HRDATA, 32'h2222_0001);
    check("post_rst_resp", HRESP, 0);
    check("post_rst_cnt", err_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
